// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: flag bit indices, flag vector type and port ids.
// The flag bit indices are also used by the branch-condition logic.
package alu_sched_pkg;

    localparam int unsigned FLAG_SF   = 4;
    localparam int unsigned FLAG_ZF   = 3;
    localparam int unsigned FLAG_CF   = 2;
    localparam int unsigned FLAG_VF   = 1;
    localparam int unsigned FLAG_PF   = 0;
    localparam int unsigned FLAGS_W   = 5;
    localparam int unsigned NUM_PORTS = 2;

    typedef logic [FLAGS_W-1:0] flags_t;

    // Identifies a requester port; also used to remember the last grant.
    typedef enum logic {
        Port0 = 1'b0,
        Port1 = 1'b1
    } port_e;

endpackage

// File: rtl/alu_sched_arb.sv
// Two-request arbiter, purely combinational.
//   req_i       : request vector, bit i = port i eligible
//   fixed_pri_i : 1 = port 0 always wins a conflict, 0 = round-robin
//   last_i      : port granted most recently (the flop lives in the parent)
//   gnt_o       : one-hot grant, or zero when nothing requests
module rr_arb2
    import alu_sched_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       fixed_pri_i,
    input  port_e      last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            // On conflict the port that did not win last time goes next.
            gnt_o = (fixed_pri_i || (last_i == Port1)) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one combinational ALU between the execute stage (port 0) and address generation
// (port 1). One request is granted per cycle; its ALU result is registered into that port's
// response slot. Owns the architectural flag register, written only by port-0 operations.
//   pX_valid/pX_ready/pX_ir/pX_sr/pX_tr : request channel per port (ready is the grant)
//   pX_rvalid/pX_rready/pX_dr           : response slot per port
//   alu_ir/alu_sr/alu_tr                : operands to the shared ALU, zero when idle
//   alu_dr/alu_flags/alu_flag_up        : ALU result, flags and flag-update strobe
//   flags                               : architectural {sf,zf,cf,vf,pf}
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned W         = 32,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         p0_valid,
    output logic         p0_ready,
    input  logic [W-1:0] p0_ir,
    input  logic [W-1:0] p0_sr,
    input  logic [W-1:0] p0_tr,
    output logic         p0_rvalid,
    input  logic         p0_rready,
    output logic [W-1:0] p0_dr,

    input  logic         p1_valid,
    output logic         p1_ready,
    input  logic [W-1:0] p1_ir,
    input  logic [W-1:0] p1_sr,
    input  logic [W-1:0] p1_tr,
    output logic         p1_rvalid,
    input  logic         p1_rready,
    output logic [W-1:0] p1_dr,

    output logic [W-1:0] alu_ir,
    output logic [W-1:0] alu_sr,
    output logic [W-1:0] alu_tr,
    input  logic [W-1:0] alu_dr,
    input  flags_t       alu_flags,
    input  logic         alu_flag_up,

    output flags_t       flags
);

    logic [1:0]   valid;
    logic [1:0]   rready;
    logic [1:0]   rvalid;
    logic [1:0]   elig;
    logic [1:0]   gnt;
    logic [W-1:0] dr [NUM_PORTS];
    logic         fixed_pri;

    port_e        last_grant_q, last_grant_d;
    flags_t       flags_q, flags_d;

    assign valid     = {p1_valid, p0_valid};
    assign rready    = {p1_rready, p0_rready};
    assign fixed_pri = (FIXED_PRI != 0);

    // A port may issue only if its slot is empty or being drained this cycle. Nothing is
    // granted while reset is asserted so the ALU sees the idle path.
    assign elig = {2{rst_n}} & valid & (~rvalid | rready);

    rr_arb2 u_arb (
        .req_i       (elig),
        .fixed_pri_i (fixed_pri),
        .last_i      (last_grant_q),
        .gnt_o       (gnt)
    );

    assign p0_ready = gnt[0];
    assign p1_ready = gnt[1];

    always_comb begin
        alu_ir = '0;
        alu_sr = '0;
        alu_tr = '0;
        if (gnt[0]) begin
            alu_ir = p0_ir;
            alu_sr = p0_sr;
            alu_tr = p0_tr;
        end else if (gnt[1]) begin
            alu_ir = p1_ir;
            alu_sr = p1_sr;
            alu_tr = p1_tr;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt[0]) begin
            last_grant_d = Port0;
        end else if (gnt[1]) begin
            last_grant_d = Port1;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (gnt[0] && alu_flag_up) begin
            flags_d = alu_flags;
        end
    end

    // Reset leaves last_grant at port 1 so port 0 wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= Port1;
            flags_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            flags_q      <= flags_d;
        end
    end

    assign flags = flags_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
        logic         rvalid_q, rvalid_d;
        logic [W-1:0] dr_q, dr_d;

        // A fire overrides a drain, giving one result per cycle back-to-back.
        always_comb begin
            rvalid_d = rvalid_q;
            dr_d     = dr_q;
            if (gnt[i]) begin
                rvalid_d = 1'b1;
                dr_d     = alu_dr;
            end else if (rready[i]) begin
                rvalid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid_q <= 1'b0;
                dr_q     <= '0;
            end else begin
                rvalid_q <= rvalid_d;
                dr_q     <= dr_d;
            end
        end

        assign rvalid[i] = rvalid_q;
        assign dr[i]     = dr_q;
    end

    assign p0_rvalid = rvalid[0];
    assign p1_rvalid = rvalid[1];
    assign p0_dr     = dr[0];
    assign p1_dr     = dr[1];

endmodule
